crtc6845_gen: RTL and testbench
===============================

Name: crtc6845_gen

Overview:
- Parametrised next-generation 6845-class CRT controller for the video subsystem (MDA/CGA-style timing).
- Generates character-clock horizontal/vertical timing, refresh address (MA) and row address (RA), DE with skew, and a cursor with hardware blink.
- Counter widths are generic; light-pen capture is an optional feature.
- Sits between the CPU I/O decoder and the video attribute/pixel pipeline.

Parameters:
- MA_W, 14, refresh address width; MA wraps modulo 2^MA_W.
- RA_W, 5, raster (scanline) counter width; also width of R9/R10/R11 fields.
- H_W, 8, horizontal char counter width; also width of R0/R1/R2.
- V_W, 7, character-row counter width; also width of R4/R6/R7.
- H_TOTAL, 113, reset value of R0.
- H_DISP, 80, reset value of R1.
- H_SYNCPOS, 90, reset value of R2.
- V_TOTAL, 31, reset value of R4.
- V_DISP, 25, reset value of R6.
- V_SYNCPOS, 28, reset value of R7.
- V_MAXSCAN, 7, reset value of R9.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- CLKEN  in  1  character-clock enable; all timing advances only when high
- nCS  in  1  chip select, active low
- R_nW  in  1  1 = read, 0 = write
- RS  in  1  0 = address register, 1 = data register
- DI  in  8  write data
- DO  out  8  read data (combinational)
- LPSTB  in  1  light-pen strobe (used only with the optional feature)
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- DE  out  1  skewed display enable
- CURSOR  out  1  skewed cursor
- MA  out  MA_W  refresh address
- RA  out  RA_W  raster address

Behaviour:
- Reset:
  - hcc, line, row, in_adj, frame_cnt, sync counters and skew pipes clear.
  - R0/R1/R2/R4/R6/R7/R9 load their parameter defaults; all other registers clear.
  - HSYNC, VSYNC, DE and CURSOR are 0; MA = start address = 0; RA = 0.
- Register bus:
  - Write on any CLOCK edge with ~nCS & ~R_nW, independent of CLKEN.
  - RS=0 latches DI[4:0] into addr; RS=1 writes R[addr].
  - Widths: R3 = {vsw[3:0], hsw[3:0]}; R8[5:4] = skew; R10 = {blink[1:0], start}; R12/R13 start address; R14/R15 cursor address. Bits above MA_W are dropped.
  - Reads: R14/R15 return their contents; with the optional feature, R16/R17 also return contents. Any other address reads 0x00. DO = 0xFF when not selected.
  - A write coincident with CLKEN: that cycle's comparisons use the old value.
- Horizontal: hcc counts 0..R0, then wraps to 0; this wrap is "line end". hde = (hcc < R1). HSYNC asserts when hcc == R2 and lasts hsw characters (hsw = 0 means 16). R0 = 0 gives a line end on every character.
- Vertical:
  - At line end, line increments; when line == R9 (or R9 = 0) it wraps to 0 and row increments.
  - After row == R4 completes: if R5 != 0, run R5 adjust lines (in_adj, line counts 0..R5-1); otherwise start a new frame.
  - vde = (row < R6); R6 = 0 keeps vde at 0.
  - VSYNC asserts at the first character of row == R7, line 0 and lasts vsw lines (vsw = 0 means 16). R7 > R4 means no VSYNC.
  - VSYNC is not retriggered in the same frame.
- Address:
  - Frame start loads row_start = {R12,R13}.
  - MA = row_start + hcc, truncated to MA_W.
  - At line end of the last line of a row, row_start += R1.
  - RA = line.
- Skew:
  - de_raw = hde & vde, delayed 0/1/2 CLKEN ticks per skew = 0/1/2. Skew = 3 forces DE = 0.
  - CURSOR uses the same delay as DE.
- Cursor:
  - cur_raw = hde & vde & (MA == {R14,R15}) & (R10.start <= line <= R11).
  - Blink gating by blink field:
    - 00: steady.
    - 01: off.
    - 10: on while frame_cnt[3] = 0 (16-frame period).
    - 11: on while frame_cnt[4] = 0 (32-frame period).
  - frame_cnt is 5 bits, increments at every frame start and wraps.
- Counter widths wrap naturally; no saturation.

Optional Feature:
- Macro: CRTC_LPEN_EN.
- Defined:
  - A 0→1 edge on LPSTB (synchronised by a two-flop stage) latches the current MA into {R16,R17}.
  - Only the first edge per frame latches; the latch re-arms at frame start.
  - R16/R17 are readable; reset clears them.
- Undefined: LPSTB is ignored, R16/R17 read 0x00, and no synchroniser logic is built.

Test Plan:
- Program R0=9, R1=6, R2=7, R3=0x22 -> HSYNC high for exactly 2 CLKEN ticks starting at hcc=7; hde high for hcc 0..5; line period 10 ticks.
- R4=3, R5=2, R6=2, R7=3, R9=1 -> frame = 4 rows × 2 lines + 2 adjust lines = 10 lines; vde spans 4 lines; VSYNC starts at row 3, line 0 and lasts 2 lines.
- R12:R13=0x0100, R1=6 -> first line MA 0x100..0x105; row 1 MA starts at 0x106; MA_W=14 with start 0x3FFE -> MA wraps to 0x0000.
- R8 skew=2 -> DE and CURSOR lag hde&vde by exactly 2 CLKEN ticks; skew=3 -> DE stays 0.
- R14:R15 = MA at hcc 2, R10=0x40|1, R11=2 -> CURSOR on lines 1..2 only when frame_cnt[3]=0; blink=01 -> never.
- CRTC_LPEN_EN defined: LPSTB pulse at MA=0x123 -> R16=0x01, R17=0x23; a second pulse in the same frame leaves them unchanged; RESET asserted mid-frame -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/crtc6845_gen.sv
// crtc6845_gen: 6845-class CRT timing generator (sync, DE, cursor, MA/RA).
// Light-pen capture into R16/R17 is built only when CRTC_LPEN_EN is defined.
module crtc6845_gen #(
    parameter int MA_W      = 14,
    parameter int RA_W      = 5,
    parameter int H_W       = 8,
    parameter int V_W       = 7,
    parameter int H_TOTAL   = 113,
    parameter int H_DISP    = 80,
    parameter int H_SYNCPOS = 90,
    parameter int V_TOTAL   = 31,
    parameter int V_DISP    = 25,
    parameter int V_SYNCPOS = 28,
    parameter int V_MAXSCAN = 7
) (
    input  logic            CLOCK,
    input  logic            RESET,
    input  logic            CLKEN,
    input  logic            nCS,
    input  logic            R_nW,
    input  logic            RS,
    input  logic [7:0]      DI,
    output logic [7:0]      DO,
    input  logic            LPSTB,
    output logic            HSYNC,
    output logic            VSYNC,
    output logic            DE,
    output logic            CURSOR,
    output logic [MA_W-1:0] MA,
    output logic [RA_W-1:0] RA
);

    logic [4:0]      addr_q;
    logic [H_W-1:0]  r0_q, r1_q, r2_q;
    logic [7:0]      r3_q;
    logic [V_W-1:0]  r4_q, r6_q, r7_q;
    logic [RA_W-1:0] r5_q, r9_q, cs_q, ce_q;
    logic [1:0]      skew_q, blink_q;
    logic [MA_W-1:0] sa_q, cur_q;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            addr_q  <= '0;
            r0_q    <= H_W'(H_TOTAL);
            r1_q    <= H_W'(H_DISP);
            r2_q    <= H_W'(H_SYNCPOS);
            r3_q    <= '0;
            r4_q    <= V_W'(V_TOTAL);
            r5_q    <= '0;
            r6_q    <= V_W'(V_DISP);
            r7_q    <= V_W'(V_SYNCPOS);
            r9_q    <= RA_W'(V_MAXSCAN);
            skew_q  <= '0;
            blink_q <= '0;
            cs_q    <= '0;
            ce_q    <= '0;
            sa_q    <= '0;
            cur_q   <= '0;
        end else if (!nCS && !R_nW) begin
            if (!RS) begin
                addr_q <= DI[4:0];
            end else begin
                case (addr_q)
                    5'd0:  r0_q <= H_W'(DI);
                    5'd1:  r1_q <= H_W'(DI);
                    5'd2:  r2_q <= H_W'(DI);
                    5'd3:  r3_q <= DI;
                    5'd4:  r4_q <= V_W'(DI);
                    5'd5:  r5_q <= RA_W'(DI);
                    5'd6:  r6_q <= V_W'(DI);
                    5'd7:  r7_q <= V_W'(DI);
                    5'd8:  skew_q <= DI[5:4];
                    5'd9:  r9_q <= RA_W'(DI);
                    5'd10: begin
                        blink_q <= DI[6:5];
                        cs_q    <= RA_W'(DI[4:0]);
                    end
                    5'd11: ce_q <= RA_W'(DI);
                    5'd12: sa_q <= MA_W'({DI, sa_q[7:0]});
                    5'd13: sa_q[7:0] <= DI;
                    5'd14: cur_q <= MA_W'({DI, cur_q[7:0]});
                    5'd15: cur_q[7:0] <= DI;
                    default: ;
                endcase
            end
        end
    end

    logic [H_W-1:0]  hcc_q, hcc_d;
    logic [RA_W-1:0] line_q, line_d;
    logic [V_W-1:0]  row_q, row_d;
    logic            in_adj_q, in_adj_d;
    logic [4:0]      fc_q, fc_d;
    logic [MA_W-1:0] rs_q, rs_d;
    logic            hs_act_q, hs_act_d, vs_act_q, vs_act_d;
    logic            vs_done_q, vs_done_d;
    logic [4:0]      hs_cnt_q, hs_cnt_d, vs_cnt_q, vs_cnt_d;
    logic [1:0]      de_p_q, cur_p_q;

    logic            line_end, frame_start, hs_start, vs_start;
    logic            hs_now, vs_now, de_raw, cur_raw, blink_ok;
    logic            de_sel, cur_sel;
    logic [4:0]      hsw_e, vsw_e, hs_cnt_now, vs_cnt_now;
    logic [MA_W-1:0] ma_now;

    // Sync width field of 0 encodes the maximum of 16.
    assign hsw_e = (r3_q[3:0] == 4'd0) ? 5'd16 : {1'b0, r3_q[3:0]};
    assign vsw_e = (r3_q[7:4] == 4'd0) ? 5'd16 : {1'b0, r3_q[7:4]};

    always_comb begin
        hcc_d       = hcc_q;
        line_d      = line_q;
        row_d       = row_q;
        in_adj_d    = in_adj_q;
        fc_d        = fc_q;
        rs_d        = rs_q;
        hs_act_d    = hs_act_q;
        hs_cnt_d    = hs_cnt_q;
        vs_act_d    = vs_act_q;
        vs_cnt_d    = vs_cnt_q;
        vs_done_d   = vs_done_q;
        frame_start = 1'b0;

        ma_now   = rs_q + MA_W'(hcc_q);
        line_end = (hcc_q == r0_q);
        hs_start = (hcc_q == r2_q);
        vs_start = !vs_done_q && !in_adj_q && (hcc_q == '0)
                   && (line_q == '0) && (row_q == r7_q);

        hs_cnt_now = hs_start ? hsw_e : hs_cnt_q;
        hs_now     = hs_start || hs_act_q;
        vs_cnt_now = vs_start ? vsw_e : vs_cnt_q;
        vs_now     = vs_start || vs_act_q;

        case (blink_q)
            2'b00:   blink_ok = 1'b1;
            2'b01:   blink_ok = 1'b0;
            2'b10:   blink_ok = !fc_q[3];
            default: blink_ok = !fc_q[4];
        endcase

        de_raw  = (hcc_q < r1_q) && (row_q < r6_q);
        cur_raw = de_raw && (ma_now == cur_q) && (cs_q <= line_q)
                  && (line_q <= ce_q) && blink_ok;

        case (skew_q)
            2'd0:    begin de_sel = de_raw;    cur_sel = cur_raw;    end
            2'd1:    begin de_sel = de_p_q[0]; cur_sel = cur_p_q[0]; end
            2'd2:    begin de_sel = de_p_q[1]; cur_sel = cur_p_q[1]; end
            default: begin de_sel = 1'b0;      cur_sel = 1'b0;       end
        endcase

        if (CLKEN) begin
            hcc_d    = line_end ? '0 : hcc_q + H_W'(1);
            hs_act_d = hs_now && (hs_cnt_now != 5'd1);
            hs_cnt_d = hs_now ? hs_cnt_now - 5'd1 : hs_cnt_now;

            if (vs_start) vs_done_d = 1'b1;
            vs_act_d = vs_now && !(line_end && vs_cnt_now == 5'd1);
            vs_cnt_d = (vs_now && line_end) ? vs_cnt_now - 5'd1 : vs_cnt_now;

            if (line_end) begin
                if (in_adj_q) begin
                    if (line_q == r5_q - RA_W'(1)) frame_start = 1'b1;
                    else line_d = line_q + RA_W'(1);
                end else if (line_q == r9_q) begin
                    line_d = '0;
                    rs_d   = rs_q + MA_W'(r1_q);
                    if (row_q == r4_q) begin
                        if (r5_q != '0) in_adj_d = 1'b1;
                        else frame_start = 1'b1;
                    end else begin
                        row_d = row_q + V_W'(1);
                    end
                end else begin
                    line_d = line_q + RA_W'(1);
                end
            end

            if (frame_start) begin
                line_d    = '0;
                row_d     = '0;
                in_adj_d  = 1'b0;
                rs_d      = sa_q;
                fc_d      = fc_q + 5'd1;
                vs_done_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hcc_q     <= '0;
            line_q    <= '0;
            row_q     <= '0;
            in_adj_q  <= 1'b0;
            fc_q      <= '0;
            rs_q      <= '0;
            hs_act_q  <= 1'b0;
            hs_cnt_q  <= '0;
            vs_act_q  <= 1'b0;
            vs_cnt_q  <= '0;
            vs_done_q <= 1'b0;
            de_p_q    <= '0;
            cur_p_q   <= '0;
            HSYNC     <= 1'b0;
            VSYNC     <= 1'b0;
            DE        <= 1'b0;
            CURSOR    <= 1'b0;
            MA        <= '0;
            RA        <= '0;
        end else if (CLKEN) begin
            hcc_q     <= hcc_d;
            line_q    <= line_d;
            row_q     <= row_d;
            in_adj_q  <= in_adj_d;
            fc_q      <= fc_d;
            rs_q      <= rs_d;
            hs_act_q  <= hs_act_d;
            hs_cnt_q  <= hs_cnt_d;
            vs_act_q  <= vs_act_d;
            vs_cnt_q  <= vs_cnt_d;
            vs_done_q <= vs_done_d;
            de_p_q    <= {de_p_q[0], de_raw};
            cur_p_q   <= {cur_p_q[0], cur_raw};
            HSYNC     <= hs_now;
            VSYNC     <= vs_now;
            DE        <= de_sel;
            CURSOR    <= cur_sel;
            MA        <= ma_now;
            RA        <= line_q;
        end
    end

    logic [15:0] cur16;
    assign cur16 = 16'(cur_q);

`ifdef CRTC_LPEN_EN
    logic [2:0]      lps_q;
    logic            lp_arm_q;
    logic [MA_W-1:0] lpa_q;
    logic [15:0]     lp16;

    assign lp16 = 16'(lpa_q);

    // Only the first strobe edge of a frame is captured.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            lps_q    <= '0;
            lp_arm_q <= 1'b1;
            lpa_q    <= '0;
        end else begin
            lps_q <= {lps_q[1:0], LPSTB};
            if (lps_q[1] && !lps_q[2] && lp_arm_q) begin
                lpa_q    <= MA;
                lp_arm_q <= 1'b0;
            end
            if (CLKEN && frame_start) lp_arm_q <= 1'b1;
        end
    end
`else
    logic unused_lpstb;
    assign unused_lpstb = LPSTB;
`endif

    always_comb begin
        DO = 8'hFF;
        if (!nCS) begin
            DO = 8'h00;
            if (RS) begin
                case (addr_q)
                    5'd14: DO = cur16[15:8];
                    5'd15: DO = cur16[7:0];
`ifdef CRTC_LPEN_EN
                    5'd16: DO = lp16[15:8];
                    5'd17: DO = lp16[7:0];
`endif
                    default: DO = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_crtc6845_gen.sv
// tb_crtc6845_gen: directed and randomized checks of crtc6845_gen
// against a frame-arithmetic reference model.
module tb_crtc6845_gen;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        CLKEN = 1'b0;
    logic        nCS   = 1'b1;
    logic        R_nW  = 1'b1;
    logic        RS    = 1'b0;
    logic [7:0]  DI    = '0;
    logic [7:0]  DO;
    logic        LPSTB = 1'b0;
    logic        HSYNC, VSYNC, DE, CURSOR;
    logic [13:0] MA;
    logic [4:0]  RA;

    crtc6845_gen dut (
        .CLOCK(CLOCK), .RESET(RESET), .CLKEN(CLKEN), .nCS(nCS),
        .R_nW(R_nW), .RS(RS), .DI(DI), .DO(DO), .LPSTB(LPSTB),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE), .CURSOR(CURSOR),
        .MA(MA), .RA(RA)
    );

    always #5 CLOCK = ~CLOCK;

    int n_chk = 0;
    int n_fail = 0;
    int s_cnt = 0;

    int c_r0, c_r1, c_r2, c_hsw, c_r4, c_r5, c_r6, c_r7, c_vsw, c_r9;
    int c_skew, c_sa, c_cur, c_cs, c_ce, c_blink;

    typedef struct {
        int h;
        int line;
        int row;
        int f;
        int ma;
    } pos_t;

    // Screen position of state index s, from frame geometry.
    function automatic pos_t decode(int s);
        pos_t p;
        int L, rows, fl, r, ln, rdone;
        L    = c_r0 + 1;
        rows = (c_r4 + 1) * (c_r9 + 1);
        fl   = rows + c_r5;
        p.f  = s / (L * fl);
        r    = s % (L * fl);
        ln   = r / L;
        p.h  = r % L;
        if (ln < rows) begin
            p.row  = ln / (c_r9 + 1);
            p.line = ln % (c_r9 + 1);
            rdone  = p.row;
        end else begin
            p.row  = c_r4;
            p.line = ln - rows;
            rdone  = c_r4 + 1;
        end
        p.ma = ((p.f == 0 ? 0 : c_sa) + rdone * c_r1 + p.h) % 16384;
        return p;
    endfunction

    function automatic logic de_raw(int s);
        pos_t p;
        p = decode(s);
        return (p.h < c_r1) && (p.row < c_r6);
    endfunction

    function automatic logic blink_on(int f);
        case (c_blink)
            0: return 1'b1;
            1: return 1'b0;
            2: return ((f % 32) & 8) == 0;
            default: return ((f % 32) & 16) == 0;
        endcase
    endfunction

    function automatic logic cur_raw(int s);
        pos_t p;
        p = decode(s);
        return de_raw(s) && (p.ma == c_cur) && (c_cs <= p.line)
               && (p.line <= c_ce) && blink_on(p.f);
    endfunction

    function automatic logic hs_exp(int s);
        pos_t p;
        for (int j = 0; j < c_hsw; j++) begin
            if (s - j >= 0) begin
                p = decode(s - j);
                if (p.h == c_r2) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic vs_line(int gl);
        int rows, ln;
        rows = (c_r4 + 1) * (c_r9 + 1);
        ln   = gl % (rows + c_r5);
        if (ln >= rows) return 1'b0;
        return (ln / (c_r9 + 1) == c_r7) && (ln % (c_r9 + 1) == 0);
    endfunction

    function automatic logic vs_exp(int s);
        int g;
        g = s / (c_r0 + 1);
        for (int j = 0; j < c_vsw; j++)
            if (g - j >= 0 && vs_line(g - j)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (tick %0d)",
                   tag, got, exp, s_cnt);
        end
    endtask

    task automatic check_outs(input int s);
        pos_t p;
        logic e_de, e_cur;
        p = decode(s);
        if (c_skew == 3 || s < c_skew) begin
            e_de  = 1'b0;
            e_cur = 1'b0;
        end else begin
            e_de  = de_raw(s - c_skew);
            e_cur = cur_raw(s - c_skew);
        end
        check("MA", 32'(MA), p.ma);
        check("RA", 32'(RA), p.line);
        check("HSYNC", 32'(HSYNC), 32'(hs_exp(s)));
        check("VSYNC", 32'(VSYNC), 32'(vs_exp(s)));
        check("DE", 32'(DE), 32'(e_de));
        check("CURSOR", 32'(CURSOR), 32'(e_cur));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLOCK);
            CLKEN = 1'b1;
            @(posedge CLOCK);
            #1;
            check_outs(s_cnt);
            s_cnt++;
        end
        @(negedge CLOCK);
        CLKEN = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        CLKEN = 1'b0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        s_cnt = 0;
    endtask

    task automatic wr(input int a, input int d);
        @(negedge CLOCK);
        nCS = 1'b0; R_nW = 1'b0; RS = 1'b0; DI = 8'(a);
        @(negedge CLOCK);
        RS = 1'b1; DI = 8'(d);
        @(negedge CLOCK);
        nCS = 1'b1; R_nW = 1'b1;
    endtask

    task automatic rd(input string tag, input int a, input int exp);
        @(negedge CLOCK);
        nCS = 1'b0; R_nW = 1'b0; RS = 1'b0; DI = 8'(a);
        @(negedge CLOCK);
        R_nW = 1'b1; RS = 1'b1;
        #1;
        check(tag, 32'(DO), exp);
        @(negedge CLOCK);
        nCS = 1'b1;
    endtask

    task automatic set_defaults();
        c_r0 = 113; c_r1 = 80; c_r2 = 90; c_hsw = 16;
        c_r4 = 31; c_r5 = 0; c_r6 = 25; c_r7 = 28; c_vsw = 16; c_r9 = 7;
        c_skew = 0; c_sa = 0; c_cur = 0; c_cs = 0; c_ce = 0; c_blink = 0;
    endtask

    task automatic program_cfg();
        wr(0, c_r0); wr(1, c_r1); wr(2, c_r2);
        wr(3, ((c_vsw % 16) << 4) | (c_hsw % 16));
        wr(4, c_r4); wr(5, c_r5); wr(6, c_r6); wr(7, c_r7);
        wr(8, c_skew << 4); wr(9, c_r9);
        wr(10, (c_blink << 5) | c_cs); wr(11, c_ce);
        wr(12, c_sa >> 8); wr(13, c_sa & 255);
        wr(14, c_cur >> 8); wr(15, c_cur & 255);
    endtask

    task automatic cfg_a();
        c_r0 = 9; c_r1 = 6; c_r2 = 7; c_hsw = 2;
        c_r4 = 3; c_r5 = 2; c_r6 = 2; c_r7 = 3; c_vsw = 2; c_r9 = 1;
        c_skew = 2; c_sa = 'h100; c_cur = 'h102; c_cs = 1; c_ce = 2;
        c_blink = 2;
    endtask

    task automatic rand_cfg();
        c_r0 = $urandom_range(12, 3);
        c_r1 = $urandom_range(c_r0 + 1, 1);
        c_r2 = $urandom_range(c_r0, 0);
        c_hsw = $urandom_range(16, 1);
        c_r9 = $urandom_range(3, 0);
        c_r4 = $urandom_range(4, 0);
        c_r5 = $urandom_range(2, 0);
        c_r6 = $urandom_range(c_r4 + 2, 0);
        c_r7 = $urandom_range(c_r4 + 1, 0);
        c_vsw = $urandom_range(16, 1);
        c_skew = $urandom_range(3, 0);
        c_sa = $urandom_range(16383, 0);
        c_cur = (c_sa + $urandom_range((c_r4 + 1) * c_r1 + c_r0, 0)) % 16384;
        c_cs = $urandom_range(c_r9, 0);
        c_ce = $urandom_range(c_r9 + 1, c_cs);
        c_blink = $urandom_range(3, 0);
    endtask

`ifdef CRTC_LPEN_EN
    task automatic lp_pulse();
        @(negedge CLOCK);
        LPSTB = 1'b1;
        repeat (4) @(negedge CLOCK);
        LPSTB = 1'b0;
        repeat (4) @(negedge CLOCK);
    endtask
`endif

    initial begin
        // Reset state
        do_reset();
        #1;
        check("rst_HSYNC", 32'(HSYNC), 0);
        check("rst_VSYNC", 32'(VSYNC), 0);
        check("rst_DE", 32'(DE), 0);
        check("rst_CURSOR", 32'(CURSOR), 0);
        check("rst_MA", 32'(MA), 0);
        check("rst_RA", 32'(RA), 0);
        check("DO_unselected", 32'(DO), 'hFF);

        // Parameter defaults, cursor at address 0 line 0
        set_defaults();
        run(400);

        // Directed timing, addressing, skew 2, 16-frame blink
        do_reset();
        cfg_a();
        program_cfg();
        rd("rd_R14", 14, 'h01);
        rd("rd_R15", 15, 'h02);
        rd("rd_R0", 0, 'h00);
`ifndef CRTC_LPEN_EN
        rd("rd_R16_off", 16, 'h00);
`endif
        run(4000);
        run(37);

        // Mid-frame reset clears outputs on the next edge
        @(negedge CLOCK);
        RESET = 1'b1;
        CLKEN = 1'b1;
        @(posedge CLOCK);
        #1;
        check("mid_rst_HSYNC", 32'(HSYNC), 0);
        check("mid_rst_VSYNC", 32'(VSYNC), 0);
        check("mid_rst_DE", 32'(DE), 0);
        check("mid_rst_CURSOR", 32'(CURSOR), 0);
        check("mid_rst_MA", 32'(MA), 0);
        check("mid_rst_RA", 32'(RA), 0);
        @(negedge CLOCK);
        RESET = 1'b0;
        CLKEN = 1'b0;

`ifdef CRTC_LPEN_EN
        begin
            pos_t p;
            int tgt;
            do_reset();
            cfg_a();
            c_sa = 'h11D;
            program_cfg();
            tgt = 0;
            for (int s = 0; s < 1000; s++) begin
                p = decode(s);
                if (tgt == 0 && p.f == 1 && p.ma == 'h123) tgt = s;
            end
            run(tgt + 1 - s_cnt);
            lp_pulse();
            rd("lp_R16", 16, 'h01);
            rd("lp_R17", 17, 'h23);
            run(5);
            lp_pulse();
            rd("lp_R16_hold", 16, 'h01);
            rd("lp_R17_hold", 17, 'h23);
        end
`endif

        // MA wrap at 2^14, skew 3, blink off
        do_reset();
        c_r0 = 9; c_r1 = 6; c_r2 = 3; c_hsw = 1;
        c_r4 = 1; c_r5 = 0; c_r6 = 2; c_r7 = 1; c_vsw = 1; c_r9 = 0;
        c_skew = 3; c_sa = 'h3FFE; c_cur = 0; c_cs = 0; c_ce = 0;
        c_blink = 1;
        program_cfg();
        run(300);
        wr(14, 'hFF);
        rd("rd_R14_trunc", 14, 'h3F);

        // Randomized geometries
        for (int k = 0; k < 5; k++) begin
            do_reset();
            rand_cfg();
            program_cfg();
            run(1500);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
